// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: each requester gets a one-entry posted-write
// buffer and a blocking read path to a single RAM port. Writes and reads
// share the RAM through a round-robin FSM with registered outputs.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_rd_en,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_wr_en,
    input  logic [31:0]       p0_wr_data,
    output logic [31:0]       p0_rd_data,
    output logic              p0_rd_valid,
    input  logic              p1_rd_en,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_wr_en,
    input  logic [31:0]       p1_wr_data,
    output logic [31:0]       p1_rd_data,
    output logic              p1_rd_valid,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    output logic [31:0]       ram_wr_data,
    input  logic [31:0]       ram_rd_data,
    input  logic              ram_rd_valid,
    output logic              busy,
    output logic              grant,
    output logic [1:0]        err
);

    localparam int               CNT_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, RD, RD_DONE, WR} state_t;

    // Per-port request vectors, indexed by port number
    logic [1:0]                   rd_en;
    logic [1:0]                   wr_en;
    logic [1:0][ADDR_W-1:0]       addr_in;
    logic [1:0][31:0]             wr_data_in;

    assign rd_en      = {p1_rd_en, p0_rd_en};
    assign wr_en      = {p1_wr_en, p0_wr_en};
    assign addr_in    = {p1_addr, p0_addr};
    assign wr_data_in = {p1_wr_data, p0_wr_data};

    // Write buffers
    logic [1:0]                   pend_q;
    logic [1:0][ADDR_W-1:0]       wb_addr_q;
    logic [1:0][31:0]             wb_data_q;
    logic                         ovf_q;
    logic [1:0]                   issue_wr;

    // FSM state and registered outputs
    state_t                       state_q, state_d;
    logic                         ram_rd_en_q, ram_rd_en_d;
    logic [ADDR_W-1:0]            ram_addr_q, ram_addr_d;
    logic                         ram_wr_en_q, ram_wr_en_d;
    logic [31:0]                  ram_wr_data_q, ram_wr_data_d;
    logic [1:0][31:0]             rd_data_q, rd_data_d;
    logic [1:0]                   rd_valid_q, rd_valid_d;
    logic                         busy_q, busy_d;
    logic                         grant_q, grant_d;
    logic                         last_q, last_d;
    logic                         tmo_q, tmo_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [1:0]                   cand;
    logic                         sel;

    // Next-state and next-output logic for the arbiter FSM
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        ram_rd_en_d   = ram_rd_en_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_en_d   = 1'b0;
        ram_wr_data_d = ram_wr_data_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 2'b00;
        grant_d       = grant_q;
        last_d        = last_q;
        tmo_d         = tmo_q;
        cnt_d         = cnt_q;
        issue_wr      = 2'b00;
        cand          = pend_q | rd_en;
        sel           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cand != 2'b00) begin
                    // Tie goes to the port that did not own the last grant
                    sel     = (cand == 2'b11) ? ~last_q : cand[1];
                    grant_d = sel;
                    last_d  = sel;
                    if (pend_q[sel]) begin
                        // Pending write beats the same port's read
                        issue_wr[sel] = 1'b1;
                        state_d       = WR;
                        ram_wr_en_d   = 1'b1;
                        ram_addr_d    = wb_addr_q[sel];
                        ram_wr_data_d = wb_data_q[sel];
                    end else begin
                        state_d     = RD;
                        ram_rd_en_d = 1'b1;
                        ram_addr_d  = addr_in[sel];
                        cnt_d       = '0;
                    end
                end
            end
            RD: begin
                if (ram_rd_valid) begin
                    ram_rd_en_d          = 1'b0;
                    rd_data_d[grant_q]   = ram_rd_data;
                    rd_valid_d[grant_q]  = 1'b1;
                    state_d              = RD_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    ram_rd_en_d          = 1'b0;
                    rd_data_d[grant_q]   = TIMEOUT_DATA;
                    rd_valid_d[grant_q]  = 1'b1;
                    tmo_d                = 1'b1;
                    state_d              = RD_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_DONE: state_d = IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ram_rd_en_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_data_q <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 2'b00;
            busy_q        <= 1'b0;
            grant_q       <= 1'b0;
            last_q        <= 1'b1;
            tmo_q         <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            state_q       <= state_d;
            ram_rd_en_q   <= ram_rd_en_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_wr_data_q <= ram_wr_data_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            busy_q        <= busy_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            tmo_q         <= tmo_d;
            cnt_q         <= cnt_d;
        end
    end

    // Write buffers: load on each pulse, drop a pulse that would overwrite an unissued entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the small buffer arrays are reset too, so ram_wr_data never carries X from an empty entry.
            pend_q    <= 2'b00;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i] && pend_q[i] && !issue_wr[i]) begin
                    ovf_q <= 1'b1;
                end else if (wr_en[i]) begin
                    pend_q[i]    <= 1'b1;
                    wb_addr_q[i] <= addr_in[i];
                    wb_data_q[i] <= wr_data_in[i];
                end else if (issue_wr[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    assign p0_rd_data  = rd_data_q[0];
    assign p1_rd_data  = rd_data_q[1];
    assign p0_rd_valid = rd_valid_q[0];
    assign p1_rd_valid = rd_valid_q[1];
    assign ram_rd_en   = ram_rd_en_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_wr_data = ram_wr_data_q;
    assign busy        = busy_q;
    assign grant       = grant_q;
    assign err         = {ovf_q, tmo_q};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected RAM
// strobes and completions; a negedge monitor pops and compares them.
module tb_mem_arbiter;

    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 64;
    localparam int RAM_LAT = 3;

    typedef enum logic [1:0] {EV_RDREQ, EV_WR, EV_CMP} ev_kind_t;
    typedef struct {
        ev_kind_t          kind;
        logic              port;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                len;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              p0_rd_en = 1'b0, p1_rd_en = 1'b0;
    logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
    logic              p0_wr_en = 1'b0, p1_wr_en = 1'b0;
    logic [31:0]       p0_wr_data = '0, p1_wr_data = '0;
    logic [31:0]       p0_rd_data, p1_rd_data;
    logic              p0_rd_valid, p1_rd_valid;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr_en;
    logic [31:0]       ram_wr_data;
    logic [31:0]       ram_rd_data = '0;
    logic              ram_rd_valid = 1'b0;
    logic              busy;
    logic              grant;
    logic [1:0]        err;

    int  n_checks = 0;
    int  n_pass   = 0;
    ev_t sb_q[$];
    bit  ram_silent  = 1'b0;
    bit  prev_rd_en  = 1'b0;
    int  burst_len   = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .p0_rd_en(p0_rd_en), .p0_addr(p0_addr), .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data),
        .p0_rd_data(p0_rd_data), .p0_rd_valid(p0_rd_valid),
        .p1_rd_en(p1_rd_en), .p1_addr(p1_addr), .p1_wr_en(p1_wr_en), .p1_wr_data(p1_wr_data),
        .p1_rd_data(p1_rd_data), .p1_rd_valid(p1_rd_valid),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_wr_en(ram_wr_en),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data), .ram_rd_valid(ram_rd_valid),
        .busy(busy), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_model(input logic [ADDR_W-1:0] a);
        return (a == 16'h0010) ? 32'h1234_5678 : {16'hC0DE, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic p, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input int len);
        ev_t e;
        e.kind = k; e.port = p; e.addr = a; e.data = d; e.len = len;
        sb_q.push_back(e);
    endtask

    task automatic pop_ev(input string what, output ev_t e, output bit ok);
        ok = (sb_q.size() != 0);
        check({what, "_expected"}, 32'(ok), 32'd1);
        if (ok) e = sb_q.pop_front();
    endtask

    task automatic check_cmp(input logic p, input logic [31:0] d);
        ev_t e;
        bit  ok;
        pop_ev(p ? "cmp_p1" : "cmp_p0", e, ok);
        if (ok) begin
            check("cmp_kind", 32'(e.kind), 32'(EV_CMP));
            check("cmp_port", 32'(p), 32'(e.port));
            check("cmp_data", d, e.data);
            check("cmp_grant", 32'(grant), 32'(e.port));
            check("cmp_ram_rd_en_low", 32'(ram_rd_en), 32'd0);
            check("cmp_burst_len", 32'(burst_len), 32'(e.len));
        end
    endtask

    // RAM model: answers a held read after RAM_LAT cycles unless silenced
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst || !ram_rd_en) begin
                cnt = 0;
                ram_rd_valid = 1'b0;
            end else begin
                cnt++;
                if (!ram_silent && cnt == RAM_LAT) begin
                    ram_rd_valid = 1'b1;
                    ram_rd_data  = ram_model(ram_addr);
                end else begin
                    ram_rd_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: every RAM strobe and completion must match the next expectation
    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (!rst) begin
            if (ram_rd_en && !prev_rd_en) begin
                burst_len = 0;
                pop_ev("ram_rd", e, ok);
                if (ok) begin
                    check("ram_rd_kind", 32'(e.kind), 32'(EV_RDREQ));
                    check("ram_rd_addr", 32'(ram_addr), 32'(e.addr));
                end
            end
            if (ram_rd_en) burst_len++;
            if (ram_wr_en) begin
                pop_ev("ram_wr", e, ok);
                if (ok) begin
                    check("ram_wr_kind", 32'(e.kind), 32'(EV_WR));
                    check("ram_wr_addr", 32'(ram_addr), 32'(e.addr));
                    check("ram_wr_data", ram_wr_data, e.data);
                end
            end
            if (p0_rd_valid) check_cmp(1'b0, p0_rd_data);
            if (p1_rd_valid) check_cmp(1'b1, p1_rd_data);
        end
        prev_rd_en = ram_rd_en;
    end

    task automatic set_rd(input bit p, input bit en, input logic [ADDR_W-1:0] a);
        if (p) begin p1_rd_en = en; p1_addr = a; end
        else   begin p0_rd_en = en; p0_addr = a; end
    endtask

    task automatic read_port(input bit p, input logic [ADDR_W-1:0] a);
        bit seen;
        seen = 1'b0;
        set_rd(p, 1'b1, a);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = p ? p1_rd_valid : p0_rd_valid;
        end
        check(p ? "rd_done_p1" : "rd_done_p0", 32'(seen), 32'd1);
        set_rd(p, 1'b0, a);
    endtask

    task automatic pulse_wr(input bit p, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        if (p) begin p1_wr_en = 1'b1; p1_addr = a; p1_wr_data = d; end
        else   begin p0_wr_en = 1'b1; p0_addr = a; p0_wr_data = d; end
        @(negedge clk);
        p0_wr_en = 1'b0;
        p1_wr_en = 1'b0;
    endtask

    task automatic wait_ram_rd(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = ram_rd_en;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},        32'(busy), 32'd0);
        check({tag, "_grant"},       32'(grant), 32'd0);
        check({tag, "_err"},         32'(err), 32'd0);
        check({tag, "_ram_rd_en"},   32'(ram_rd_en), 32'd0);
        check({tag, "_ram_wr_en"},   32'(ram_wr_en), 32'd0);
        check({tag, "_ram_addr"},    32'(ram_addr), 32'd0);
        check({tag, "_ram_wr_data"}, ram_wr_data, 32'd0);
        check({tag, "_p0_valid"},    32'(p0_rd_valid), 32'd0);
        check({tag, "_p1_valid"},    32'(p1_rd_valid), 32'd0);
        check({tag, "_p0_data"},     p0_rd_data, 32'd0);
        check({tag, "_p1_data"},     p1_rd_data, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Contention: simultaneous requests, grants 0,1,0,1
        for (int r = 0; r < 2; r++) begin
            logic [ADDR_W-1:0] a0, a1;
            a0 = ADDR_W'(16'h0100 + 4 * r);
            a1 = ADDR_W'(16'h0200 + 4 * r);
            expect_ev(EV_RDREQ, 1'b0, a0, '0, 0);
            expect_ev(EV_CMP,   1'b0, '0, ram_model(a0), RAM_LAT);
            expect_ev(EV_RDREQ, 1'b1, a1, '0, 0);
            expect_ev(EV_CMP,   1'b1, '0, ram_model(a1), RAM_LAT);
            fork
                read_port(1'b0, a0);
                read_port(1'b1, a1);
            join
        end

        // Single read
        expect_ev(EV_RDREQ, 1'b0, 16'h0010, '0, 0);
        expect_ev(EV_CMP,   1'b0, '0, 32'h1234_5678, RAM_LAT);
        read_port(1'b0, 16'h0010);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Write buffered behind a read on the other port
        expect_ev(EV_RDREQ, 1'b0, 16'h0030, '0, 0);
        expect_ev(EV_CMP,   1'b0, '0, ram_model(16'h0030), RAM_LAT);
        expect_ev(EV_WR,    1'b1, 16'h0020, 32'h0000_AA55, 0);
        fork
            read_port(1'b0, 16'h0030);
            begin
                wait_ram_rd("wb_rd_start");
                pulse_wr(1'b1, 16'h0020, 32'h0000_AA55);
            end
        join
        repeat (4) @(negedge clk);
        check("wb_err", 32'(err), 32'd0);
        check("wb_sb_drained", 32'(sb_q.size()), 32'd0);

        // Overflow and read-after-write order on port 0
        expect_ev(EV_RDREQ, 1'b1, 16'h0040, '0, 0);
        expect_ev(EV_CMP,   1'b1, '0, ram_model(16'h0040), RAM_LAT);
        expect_ev(EV_WR,    1'b0, 16'h0050, 32'h0000_0001, 0);
        expect_ev(EV_RDREQ, 1'b0, 16'h0050, '0, 0);
        expect_ev(EV_CMP,   1'b0, '0, ram_model(16'h0050), RAM_LAT);
        fork
            read_port(1'b1, 16'h0040);
            begin
                wait_ram_rd("ovf_rd_start");
                pulse_wr(1'b0, 16'h0050, 32'h0000_0001);
                pulse_wr(1'b0, 16'h0051, 32'h0000_0002);
                read_port(1'b0, 16'h0050);
            end
        join
        repeat (2) @(negedge clk);
        check("ovf_err", 32'(err), 32'd2);
        check("ovf_sb_drained", 32'(sb_q.size()), 32'd0);

        // Read timeout
        ram_silent = 1'b1;
        expect_ev(EV_RDREQ, 1'b0, 16'h0060, '0, 0);
        expect_ev(EV_CMP,   1'b0, '0, 32'hDEAD_BEEF, TIMEOUT);
        read_port(1'b0, 16'h0060);
        ram_silent = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo_err", 32'(err), 32'd3);
        check("tmo_data_held", p0_rd_data, 32'hDEAD_BEEF);

        // Reset in the middle of a read
        ram_silent = 1'b1;
        expect_ev(EV_RDREQ, 1'b1, 16'h0070, '0, 0);
        set_rd(1'b1, 1'b1, 16'h0070);
        wait_ram_rd("rst_rd_start");
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        set_rd(1'b1, 1'b0, '0);
        #1;
        check_all_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ram_silent = 1'b0;
        repeat (80) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("final_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
